// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop sync + per-channel counter debounce of pb_raw into held/press/rel pulses with saturating press_cnt (ports clk, n_rst, pb_raw, held, press, rel, press_cnt); define BTN_REPEAT_EN for press auto-repeat
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [N_BTN-1:0] pb_raw,
  output logic [N_BTN-1:0] held,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic [7:0]       press_cnt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [N_BTN-1:0] s1, s2, acc, rep;
  logic [CW-1:0] cnt [N_BTN];
  logic [8:0] sum;
  always_comb begin
    acc = '0;
    for (int i = 0; i < N_BTN; i++)
      acc[i] = (s2[i] != held[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
  end
  always_comb begin
    sum = {1'b0, press_cnt};
    for (int i = 0; i < N_BTN; i++)
      sum = sum + 9'(press[i]);
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1        <= '0;
      s2        <= '0;
      held      <= '0;
      press     <= '0;
      rel       <= '0;
      press_cnt <= '0;
      for (int i = 0; i < N_BTN; i++)
        cnt[i] <= '0;
    end else begin
      s1        <= pb_raw;
      s2        <= s1;
      held      <= held ^ acc;
      press     <= (acc & ~held) | rep;
      rel       <= acc & held;
      press_cnt <= sum[8] ? 8'hff : sum[7:0];
      for (int i = 0; i < N_BTN; i++)
        cnt[i] <= (s2[i] == held[i] || acc[i]) ? '0 : cnt[i] + CW'(1);
    end
  end
`ifdef BTN_REPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [RW-1:0] rcnt [N_BTN];
  logic [N_BTN-1:0] phase;
  always_comb begin
    rep = '0;
    for (int i = 0; i < N_BTN; i++)
      rep[i] = held[i] && !acc[i] &&
               rcnt[i] == (phase[i] ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      phase <= '0;
      for (int i = 0; i < N_BTN; i++)
        rcnt[i] <= '0;
    end else begin
      phase <= held & ~acc & (phase | rep);
      for (int i = 0; i < N_BTN; i++)
        rcnt[i] <= (!held[i] || acc[i] || rep[i]) ? '0 : rcnt[i] + RW'(1);
    end
  end
`else
  assign rep = '0;
`endif
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4
module tb_button_conditioner;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [3:0] pb_raw = '0;
  logic [3:0] held, press, rel;
  logic [7:0] press_cnt;
  int nvec = 0;
  int nerr = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .n_rst(n_rst), .pb_raw(pb_raw),
    .held(held), .press(press), .rel(rel), .press_cnt(press_cnt)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    pb_raw = '0;
    tick(2);
    nvec++; if (held !== 4'h0) begin nerr++; $display("FAIL reset_held got %h want 0", held); end
    nvec++; if (press !== 4'h0) begin nerr++; $display("FAIL reset_press got %h want 0", press); end
    nvec++; if (rel !== 4'h0) begin nerr++; $display("FAIL reset_rel got %h want 0", rel); end
    nvec++; if (press_cnt !== 8'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", press_cnt); end
    n_rst = 1'b1;
    tick(1);
  endtask

  task automatic test_press;
    pb_raw = 4'b0001;
    tick(5);
    nvec++; if (held !== 4'h0) begin nerr++; $display("FAIL press_early_held got %h want 0", held); end
    tick(1);
    nvec++; if (held !== 4'b0001) begin nerr++; $display("FAIL press_held got %h want 1", held); end
    nvec++; if (press !== 4'b0001) begin nerr++; $display("FAIL press_pulse got %h want 1", press); end
    tick(1);
    exp_cnt = 1;
    nvec++; if (press !== 4'h0) begin nerr++; $display("FAIL press_clear got %h want 0", press); end
    nvec++; if (press_cnt !== 8'(exp_cnt)) begin nerr++; $display("FAIL press_cnt got %0d want %0d", press_cnt, exp_cnt); end
    pb_raw = '0;
    tick(8);
    nvec++; if (held !== 4'h0) begin nerr++; $display("FAIL press_release_held got %h want 0", held); end
  endtask

  task automatic test_glitch;
    for (int r = 0; r < 10; r++) begin
      pb_raw = 4'b0010;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        nvec++; if ({held, press, rel} !== 12'h0) begin nerr++; $display("FAIL glitch_hi got %h want 0", {held, press, rel}); end
      end
      pb_raw = '0;
      tick(1);
      nvec++; if ({held, press, rel} !== 12'h0) begin nerr++; $display("FAIL glitch_lo got %h want 0", {held, press, rel}); end
    end
    tick(3);
    nvec++; if ({held, press, rel} !== 12'h0) begin nerr++; $display("FAIL glitch_tail got %h want 0", {held, press, rel}); end
    nvec++; if (press_cnt !== 8'(exp_cnt)) begin nerr++; $display("FAIL glitch_cnt got %0d want %0d", press_cnt, exp_cnt); end
  endtask

  task automatic test_release;
    int hits, at;
    hits = 0;
    at = 0;
    pb_raw = 4'b0100;
    tick(6);
    nvec++; if (press !== 4'b0100) begin nerr++; $display("FAIL rel_setup_press got %h want 4", press); end
    exp_cnt++;
    tick(1);
    pb_raw = '0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (rel[2]) begin hits++; at = k; end
      nvec++; if (press !== 4'h0) begin nerr++; $display("FAIL rel_no_press got %h want 0", press); end
    end
    nvec++; if (hits !== 1) begin nerr++; $display("FAIL rel_count got %0d want 1", hits); end
    nvec++; if (at !== 6) begin nerr++; $display("FAIL rel_latency got %0d want 6", at); end
    nvec++; if (held !== 4'h0) begin nerr++; $display("FAIL rel_held got %h want 0", held); end
    nvec++; if (press_cnt !== 8'(exp_cnt)) begin nerr++; $display("FAIL rel_cnt got %0d want %0d", press_cnt, exp_cnt); end
  endtask

  task automatic test_saturate;
    while (exp_cnt < 253) begin
      pb_raw = 4'b0001;
      tick(6);
      pb_raw = '0;
      tick(7);
      exp_cnt++;
    end
    nvec++; if (press_cnt !== 8'd253) begin nerr++; $display("FAIL sat_preload got %0d want 253", press_cnt); end
    pb_raw = 4'hf;
    tick(6);
    nvec++; if (press !== 4'hf) begin nerr++; $display("FAIL sat_all_press got %h want f", press); end
    nvec++; if (press_cnt !== 8'd253) begin nerr++; $display("FAIL sat_before got %0d want 253", press_cnt); end
    tick(1);
    nvec++; if (press !== 4'h0) begin nerr++; $display("FAIL sat_press_clear got %h want 0", press); end
    nvec++; if (press_cnt !== 8'd255) begin nerr++; $display("FAIL sat_cap got %0d want 255", press_cnt); end
    pb_raw = '0;
    tick(8);
    pb_raw = 4'hf;
    tick(7);
    nvec++; if (press_cnt !== 8'd255) begin nerr++; $display("FAIL sat_hold got %0d want 255", press_cnt); end
    pb_raw = '0;
    tick(8);
    exp_cnt = 255;
  endtask

  task automatic test_reset_mid;
    pb_raw = 4'b1000;
    tick(7);
    pb_raw = 4'b1001;
    tick(3);
    nvec++; if (held !== 4'b1000) begin nerr++; $display("FAIL rstmid_setup got %h want 8", held); end
    n_rst = 1'b0;
    tick(1);
    n_rst = 1'b1;
    nvec++; if ({held, press, rel} !== 12'h0) begin nerr++; $display("FAIL rstmid_outs got %h want 0", {held, press, rel}); end
    nvec++; if (press_cnt !== 8'd0) begin nerr++; $display("FAIL rstmid_cnt got %0d want 0", press_cnt); end
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      nvec++; if (press !== 4'h0) begin nerr++; $display("FAIL rstmid_early got %h want 0 at %0d", press, k); end
    end
    tick(1);
    nvec++; if (press !== 4'b1001) begin nerr++; $display("FAIL rstmid_repress got %h want 9", press); end
    nvec++; if (held !== 4'b1001) begin nerr++; $display("FAIL rstmid_held got %h want 9", held); end
    tick(1);
    exp_cnt = 2;
    nvec++; if (press_cnt !== 8'(exp_cnt)) begin nerr++; $display("FAIL rstmid_pcnt got %0d want 2", press_cnt); end
    pb_raw = '0;
    tick(8);
    nvec++; if (held !== 4'h0) begin nerr++; $display("FAIL rstmid_release got %h want 0", held); end
  endtask

`ifdef BTN_REPEAT_EN
  task automatic test_repeat;
    logic exp_p, exp_r;
    pb_raw = 4'b0001;
    tick(6);
    nvec++; if (press !== 4'b0001) begin nerr++; $display("FAIL rep_first got %h want 1", press); end
    exp_cnt++;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      exp_p = (k == 10 || k == 15 || k == 20 || k == 25 || k == 30);
      exp_r = (k == 35);
      nvec++; if (press[0] !== exp_p) begin nerr++; $display("FAIL rep_press got %b want %b at +%0d", press[0], exp_p, k); end
      nvec++; if (rel[0] !== exp_r) begin nerr++; $display("FAIL rep_rel got %b want %b at +%0d", rel[0], exp_r, k); end
      if (k == 29) pb_raw = '0;
    end
    exp_cnt += 5;
    tick(2);
    nvec++; if (press_cnt !== 8'(exp_cnt)) begin nerr++; $display("FAIL rep_cnt got %0d want %0d", press_cnt, exp_cnt); end
    nvec++; if (held !== 4'h0) begin nerr++; $display("FAIL rep_held got %h want 0", held); end
  endtask
`endif

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_release();
    test_saturate();
    test_reset_mid();
`ifdef BTN_REPEAT_EN
    test_repeat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-side stage that feeds the game core's button[3:0] input. Raw pushbutton levels from the board pins enter this block, which performs the following steps:
- 2-flop synchronisation
- per-channel counter debounce
- clean held levels, plus one-cycle press and release pulses

The game core consumes the press pulses as note strikes. A saturating press counter is provided for debug display.

Parameters:
N_BTN, 4, number of button channels
DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a level change (10 ms at 12 MHz); legal minimum 2
REPEAT_DELAY, 6000000, cycles from a press pulse to the first auto-repeat pulse (used only with BTN_REPEAT_EN)
REPEAT_PERIOD, 1200000, cycles between subsequent auto-repeat pulses (used only with BTN_REPEAT_EN)

Ports:
clk  input  1  system clock; all logic on rising edge
n_rst  input  1  synchronous active-low reset, sampled on rising clk
pb_raw  input  N_BTN  asynchronous raw button levels, 1 = pressed
held  output  N_BTN  debounced level per channel, 1 = pressed
press  output  N_BTN  one-cycle pulse on accepted 0->1 change (and on auto-repeat when enabled)
rel  output  N_BTN  one-cycle pulse on accepted 1->0 change
press_cnt  output  8  total press pulses across all channels, saturating at 255

Behaviour:
- Reset (n_rst low at a rising edge) clears everything to 0: sync flops, debounce counters, held, press, rel, press_cnt, repeat counters. Reset dominates all other activity.
- Synchroniser: s1 <= pb_raw; s2 <= s1, per channel. All later logic uses s2 only.
- Debounce, per channel i. The counter is $clog2(DEBOUNCE_CYCLES) bits wide. On each edge:
  - if s2[i] == held[i]: cnt <= 0
  - else if cnt == DEBOUNCE_CYCLES-1: held[i] <= s2[i]; cnt <= 0
  - else: cnt <= cnt+1
- Any single-cycle return of s2 to the held value restarts the count, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- press[i] and rel[i] are registered and assigned at the same edge that updates held[i]:
  - press[i] = 1 only when held goes 0->1
  - rel[i] = 1 only when held goes 1->0
  - both are 0 on every other cycle
  - press and rel of one channel are never high together
- Latency: pb_raw stable high before edge 0 gives held/press high after edge DEBOUNCE_CYCLES+1. Release latency is identical.
- Channels are fully independent. Any number of press/rel bits may be high in the same cycle.
- press_cnt adds popcount(press) each cycle and saturates at 255 (no wrap). Example: 254 plus 2 simultaneous presses gives 255.
- A button held through reset deassertion is seen as a new press after the normal latency, because held resets to 0.

Optional Feature:
BTN_REPEAT_EN
- Defined:
  - Each channel has a repeat counter, cleared whenever held[i] = 0 and on every debounce press pulse.
  - While held[i] = 1, the counter increments.
  - First auto-repeat pulse on press[i]: REPEAT_DELAY cycles after the debounce press pulse.
  - Subsequent pulses: every REPEAT_PERIOD cycles.
  - Repeat pulses count in press_cnt.
  - Release stops repeats immediately. No repeat pulse is emitted in the cycle that rel[i] is high.
- Undefined: no repeat logic. press fires exactly once per accepted press, and REPEAT_* parameters are ignored.

Test Plan:
1. DEBOUNCE_CYCLES=4; pb_raw[0] steps 0->1 before edge 0 and holds -> held[0] and press[0] high after edge 5; press[0] low after edge 6; press_cnt = 1.
2. DEBOUNCE_CYCLES=4; pb_raw[1] toggles high 3 cycles, low 1 cycle, repeated 10 times -> held[1] stays 0, no press/rel, press_cnt = 0.
3. Channel 2 pressed, then pb_raw[2] dropped to 0 -> rel[2] pulses exactly once, DEBOUNCE_CYCLES+2 edges after the drop; held[2] = 0.
4. All 4 buttons rise in the same cycle with press_cnt preloaded to 253 by 253 prior single presses -> press = 4'b1111 for one cycle; press_cnt = 255 and stays 255 on further presses.
5. n_rst asserted low for 1 cycle while channel 3 is held and mid-count on channel 0 -> all outputs 0 next cycle; channel 3 re-presses after DEBOUNCE_CYCLES+2 edges with pb_raw still high.
6. BTN_REPEAT_EN, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5; channel 0 held 30 cycles past its press -> repeat pulses at +10, +15, +20, +25, +30; press_cnt = 6; release -> no further pulses.
